// File: rtl/mem_access_unit.sv
// mem_access_unit
// Sequencer between the CPU controller/datapath and the unified instruction/data memory.
// It owns the program counter and latches fetched words into the instruction register.
// It turns one-cycle controller data requests into the memory's strobe protocol:
// setup cycle, one strobe cycle, hold cycle. The memory triggers on strobe edges, so
// the strobes come straight from flops.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   fetchReq, pcWrite, pcIn   fetch request and PC load (sampled in idle only)
//   dataReq, dataWe,          data request, write enable, address and write data
//   dataAddrIn, dataWdataIn   (sampled in idle only)
//   busy, done                not-idle flag and one-cycle completion pulse
//   pc, ir, mdr               program counter, instruction register, memory data register
//   instAdd, instruction      memory instruction port (address out, data in)
//   dataAdd, writeData,       memory data port (address/write data out, read data in)
//   data
//   memRead, memWrite         registered memory strobes
module mem_access_unit #(
    parameter int unsigned      ADDR_W   = 10,
    parameter int unsigned      DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetchReq,
    input  logic              pcWrite,
    input  logic [ADDR_W-1:0] pcIn,
    input  logic              dataReq,
    input  logic              dataWe,
    input  logic [ADDR_W-1:0] dataAddrIn,
    input  logic [DATA_W-1:0] dataWdataIn,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic [ADDR_W-1:0] instAdd,
    output logic [ADDR_W-1:0] dataAdd,
    output logic [DATA_W-1:0] writeData,
    output logic              memRead,
    output logic              memWrite,
    input  logic [DATA_W-1:0] instruction,
    input  logic [DATA_W-1:0] data
);

    typedef enum logic [2:0] {StIdle, StFetch, StDsetup, StDstrobe, StDhold} state_e;

    state_e            stateQ, stateD;
    logic [ADDR_W-1:0] pcQ, pcD;
    logic [DATA_W-1:0] irQ, irD;
    logic [DATA_W-1:0] mdrQ, mdrD;
    logic [ADDR_W-1:0] dataAddQ, dataAddD;
    logic [DATA_W-1:0] writeDataQ, writeDataD;
    logic              weQ, weD;
    logic              memReadQ, memReadD;
    logic              memWriteQ, memWriteD;
    logic              doneQ, doneD;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ     <= StIdle;
            pcQ        <= RESET_PC;
            irQ        <= '0;
            mdrQ       <= '0;
            dataAddQ   <= '0;
            writeDataQ <= '0;
            weQ        <= 1'b0;
            memReadQ   <= 1'b0;
            memWriteQ  <= 1'b0;
            doneQ      <= 1'b0;
        end else begin
            stateQ     <= stateD;
            pcQ        <= pcD;
            irQ        <= irD;
            mdrQ       <= mdrD;
            dataAddQ   <= dataAddD;
            writeDataQ <= writeDataD;
            weQ        <= weD;
            memReadQ   <= memReadD;
            memWriteQ  <= memWriteD;
            doneQ      <= doneD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        pcD        = pcQ;
        irD        = irQ;
        mdrD       = mdrQ;
        dataAddD   = dataAddQ;
        writeDataD = writeDataQ;
        weD        = weQ;
        memReadD   = 1'b0;
        memWriteD  = 1'b0;
        doneD      = 1'b0;

        unique case (stateQ)
            StIdle: begin
                // The PC load lands before FETCH, so a same-cycle fetch uses the new PC.
                if (pcWrite) begin
                    pcD = pcIn;
                end
                // Fetch has priority; a coincident data request is dropped, not queued.
                if (fetchReq) begin
                    stateD = StFetch;
                end else if (dataReq) begin
                    dataAddD   = dataAddrIn;
                    writeDataD = dataWdataIn;
                    weD        = dataWe;
                    stateD     = StDsetup;
                end
            end
            StFetch: begin
                irD    = instruction;
                pcD    = pcQ + ADDR_W'(1);
                doneD  = 1'b1;
                stateD = StIdle;
            end
            StDsetup: begin
                // Raise the strobe at the edge entering DSTROBE so it is high for that cycle only.
                memWriteD = weQ;
                memReadD  = ~weQ;
                stateD    = StDstrobe;
            end
            StDstrobe: begin
                stateD = StDhold;
            end
            StDhold: begin
                if (!weQ) begin
                    mdrD = data;
                end
                doneD  = 1'b1;
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    assign busy      = (stateQ != StIdle);
    assign done      = doneQ;
    assign pc        = pcQ;
    assign ir        = irQ;
    assign mdr       = mdrQ;
    assign instAdd   = pcQ;
    assign dataAdd   = dataAddQ;
    assign writeData = writeDataQ;
    assign memRead   = memReadQ;
    assign memWrite  = memWriteQ;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetchReq, pcWrite, dataReq, dataWe;
    logic [9:0]  pcIn, dataAddrIn;
    logic [15:0] dataWdataIn;
    logic        busy, done, memRead, memWrite;
    logic [9:0]  pc, instAdd, dataAdd;
    logic [15:0] ir, mdr, writeData, instruction, dataBus;

    logic [15:0] mem [1024];

    typedef struct packed {
        logic [15:0] ir;
        logic [9:0]  pc;
        logic [15:0] mdr;
    } exp_t;

    exp_t sb[$];
    int   nVec = 0;
    int   nErr = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .fetchReq   (fetchReq),
        .pcWrite    (pcWrite),
        .pcIn       (pcIn),
        .dataReq    (dataReq),
        .dataWe     (dataWe),
        .dataAddrIn (dataAddrIn),
        .dataWdataIn(dataWdataIn),
        .busy       (busy),
        .done       (done),
        .pc         (pc),
        .ir         (ir),
        .mdr        (mdr),
        .instAdd    (instAdd),
        .dataAdd    (dataAdd),
        .writeData  (writeData),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .instruction(instruction),
        .data       (dataBus)
    );

    // Memory model: combinational instruction port, edge-triggered data port.
    assign instruction = mem[instAdd];
    initial dataBus = '0;
    always @(posedge memRead) dataBus = mem[dataAdd];
    always @(posedge memWrite) mem[dataAdd] = writeData;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        check("strobe_exclusive", {31'd0, memRead & memWrite}, 32'd0);
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_ir", {16'd0, ir}, {16'd0, e.ir});
                check("sb_pc", {22'd0, pc}, {22'd0, e.pc});
                check("sb_mdr", {16'd0, mdr}, {16'd0, e.mdr});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        fetchReq    = 1'b0;
        pcWrite     = 1'b0;
        dataReq     = 1'b0;
        dataWe      = 1'b0;
        pcIn        = '0;
        dataAddrIn  = '0;
        dataWdataIn = '0;
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_pc"}, {22'd0, pc}, 32'd0);
        check({tag, "_ir"}, {16'd0, ir}, 32'd0);
        check({tag, "_mdr"}, {16'd0, mdr}, 32'd0);
        check({tag, "_dataAdd"}, {22'd0, dataAdd}, 32'd0);
        check({tag, "_writeData"}, {16'd0, writeData}, 32'd0);
        check({tag, "_strobes"}, {30'd0, memRead, memWrite}, 32'd0);
        check({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    endtask

    // Cycle 0 = call time; returns in the done cycle (cycle 2).
    task automatic doFetch(input logic [15:0] eIr, input logic [9:0] ePc,
                           input logic [15:0] eMdr, input logic [9:0] eAddr);
        fetchReq = 1'b1;
        sb.push_back('{ir: eIr, pc: ePc, mdr: eMdr});
        step();
        idleInputs();
        check("fetch_busy", {31'd0, busy}, 32'd1);
        check("fetch_instAdd", {22'd0, instAdd}, {22'd0, eAddr});
        step();
        check("fetch_done", {30'd0, done, busy}, 32'd2);
    endtask

    // Cycle 0 = call time; returns in the done cycle (cycle 4).
    task automatic doData(input logic we, input logic [9:0] addr, input logic [15:0] wd,
                          input logic [15:0] eIr, input logic [9:0] ePc,
                          input logic [15:0] eMdr);
        dataReq     = 1'b1;
        dataWe      = we;
        dataAddrIn  = addr;
        dataWdataIn = wd;
        sb.push_back('{ir: eIr, pc: ePc, mdr: eMdr});
        step();
        idleInputs();
        check("dsetup_strobes", {30'd0, memRead, memWrite}, 32'd0);
        check("dsetup_dataAdd", {22'd0, dataAdd}, {22'd0, addr});
        step();
        check("dstrobe_strobes", {30'd0, memRead, memWrite}, {30'd0, ~we, we});
        check("dstrobe_dataAdd", {22'd0, dataAdd}, {22'd0, addr});
        step();
        check("dhold_strobes", {30'd0, memRead, memWrite}, 32'd0);
        check("dhold_busy_done", {30'd0, busy, done}, 32'd2);
        step();
        check("data_done", {30'd0, busy, done}, 32'd1);
        check("data_hold_addr", {22'd0, dataAdd}, {22'd0, addr});
        if (we) check("data_hold_wdata", {16'd0, writeData}, {16'd0, wd});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0]     = 16'h8080;
        mem[1]     = 16'hE000;
        mem[10'h3FF] = 16'h1234;
        idleInputs();
        rst = 1'b1;
        step();
        step();
        checkResetState("reset");
        rst = 1'b0;
        step();

        // Back-to-back fetches: the second is issued in the first's done cycle.
        doFetch(16'h8080, 10'd1, 16'h0000, 10'd0);
        doFetch(16'hE000, 10'd2, 16'h0000, 10'd1);

        // Write then read back the same word.
        doData(1'b1, 10'h1F5, 16'hABCD, 16'hE000, 10'd2, 16'h0000);
        doData(1'b0, 10'h1F5, 16'h0000, 16'hE000, 10'd2, 16'hABCD);

        // Jump to the top of memory with a same-cycle fetch; PC wraps to 0.
        pcWrite = 1'b1;
        pcIn    = 10'h3FF;
        doFetch(16'h1234, 10'h000, 16'hABCD, 10'h3FF);

        // Fetch and data request together: fetch wins, data dropped.
        fetchReq    = 1'b1;
        dataReq     = 1'b1;
        dataWe      = 1'b1;
        dataAddrIn  = 10'h005;
        dataWdataIn = 16'hDEAD;
        sb.push_back('{ir: 16'h8080, pc: 10'd1, mdr: 16'hABCD});
        step();
        // Requests and a PC load during FETCH are ignored.
        fetchReq = 1'b0;
        dataReq  = 1'b1;
        pcWrite  = 1'b1;
        pcIn     = 10'h200;
        check("prio_instAdd", {22'd0, instAdd}, 32'd0);
        step();
        idleInputs();
        check("prio_pc", {22'd0, pc}, 32'd1);
        check("prio_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("prio_no_access", {29'd0, busy, memRead, memWrite}, 32'd0);
            step();
        end
        check("prio_dataAdd", {22'd0, dataAdd}, 32'h1F5);

        // Reset during the strobe cycle of a write.
        dataReq     = 1'b1;
        dataWe      = 1'b1;
        dataAddrIn  = 10'h003;
        dataWdataIn = 16'h7777;
        step();
        idleInputs();
        step();
        check("abort_strobe", {30'd0, memRead, memWrite}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkResetState("abort");
        for (int i = 0; i < 4; i++) step();

        // Fetch resumes from the reset PC.
        doFetch(16'h8080, 10'd1, 16'h0000, 10'd0);
        step();
        step();
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequencer between the CPU controller/datapath and the unified 1K x 16 instruction/data memory. It owns the program counter and drives the memory's instruction address port. It latches fetched words into an instruction register. It converts single-cycle controller data requests into the edge-sensitive, glitch-free `memRead`/`memWrite` strobe protocol the memory requires, capturing read data into a memory data register.

## Interface
- `ADDR_W`, 10, word address width (memory depth 2^ADDR_W)
- `DATA_W`, 16, word width
- `RESET_PC`, 0, PC value after reset
- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `fetchReq`  in  1  request instruction fetch at PC (sampled in IDLE only)
- `pcWrite`  in  1  load PC from `pcIn` (sampled in IDLE only)
- `pcIn`  in  ADDR_W  jump/branch target
- `dataReq`  in  1  request data access (sampled in IDLE only)
- `dataWe`  in  1  1 = write, 0 = read; qualifies `dataReq`
- `dataAddrIn`  in  ADDR_W  data address
- `dataWdataIn`  in  DATA_W  write data
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle completion pulse
- `pc`  out  ADDR_W  current PC
- `ir`  out  DATA_W  instruction register
- `mdr`  out  DATA_W  memory data register (last read)
- `instAdd`  out  ADDR_W  to memory; equals `pc` register
- `dataAdd`  out  ADDR_W  to memory; latched request address
- `writeData`  out  DATA_W  to memory; latched write data
- `memRead`  out  1  to memory; registered strobe
- `memWrite`  out  1  to memory; registered strobe
- `instruction`  in  DATA_W  from memory (combinational on `instAdd`)
- `data`  in  DATA_W  from memory (valid after `memRead` rising edge)

## Operation
- States: IDLE, FETCH, DSETUP, DSTROBE, DHOLD.
- IDLE: if `pcWrite`, PC <= `pcIn`. If `fetchReq`, go FETCH. Otherwise, if `dataReq`, latch `dataAddrIn`/`dataWdataIn`/`dataWe` and go DSETUP.
- Same-cycle `pcWrite` + `fetchReq`: the fetch uses the new PC (`pcIn`).
- Same-cycle `fetchReq` + `dataReq`: the fetch wins and `dataReq` is dropped, not queued. The controller must re-present it.
- Requests and `pcWrite` while `busy` are ignored. No state changes.
- FETCH (1 cycle): `instAdd` stable. At the closing edge: `ir` <= `instruction`, PC <= PC+1 modulo 2^ADDR_W (0x3FF -> 0x000), go IDLE, `done` <= 1.
- DSETUP (1 cycle): address/data driven, strobes low.
- DSTROBE (1 cycle): `memWrite` = latched we, `memRead` = !latched we. Exactly one strobe is high.
- DHOLD (1 cycle): strobes low, address/data held. At the closing edge: if read, `mdr` <= `data`. Go IDLE, `done` <= 1.
- `memRead`/`memWrite` are flop outputs only (the memory triggers on their edges). They are never both high and never high outside DSTROBE.
- `dataAdd`/`writeData` hold their values after completion until the next accepted data request.
- `mdr` is unchanged by writes; `ir` is unchanged by data accesses.

## Timing
- Cycle 0 = request sampled in IDLE.
- Fetch: FETCH in cycle 1; `ir`/`pc` updated and `done`=1 in cycle 2; `busy` high in cycle 1 only.
- Data: DSETUP cycle 1, DSTROBE cycle 2, DHOLD cycle 3. `done`=1 and `mdr` valid in cycle 4. `busy` is high in cycles 1-3.
- In the `done` cycle the FSM is in IDLE and may accept a new request (back-to-back fetches: one every 2 cycles; data: one every 4).
- Reset values: state IDLE, `pc`=RESET_PC, `ir`=0, `mdr`=0, `dataAdd`=0, `writeData`=0, `memRead`=0, `memWrite`=0, `done`=0, `busy`=0.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values.
  - No `done` pulse for the aborted access.
  - A strobe already raised has triggered the memory. A write may have completed; `mdr` stays 0.

## Test plan
- Reset: assert `rst` 1 cycle mid-run -> `pc`=0, `ir`=0, `mdr`=0, `memRead`=`memWrite`=0, `busy`=0, `done`=0.
- Fetch: memory model mem[0]=16'h8080, mem[1]=16'hE000; pulse `fetchReq` twice -> first `done` in cycle 2 with `ir`=16'h8080, `pc`=1; second gives `ir`=16'hE000, `pc`=2.
- Write/read: `dataReq`, `dataWe`=1, addr 10'h1F5, wdata 16'hABCD -> `memWrite` high in cycle 2 only, `dataAdd`=10'h1F5 in cycles 1-3, `done` in cycle 4. Then a read of 10'h1F5 -> `memRead` high in cycle 2 only, `mdr`=16'hABCD in cycle 4.
- Jump + wrap: `pcWrite`, `pcIn`=10'h3FF with `fetchReq` -> `instAdd`=10'h3FF during FETCH, `ir`=mem[0x3FF], `pc`=10'h000.
- Priority/busy: `fetchReq`+`dataReq` same cycle -> fetch only, no strobe ever. `dataReq` and `pcWrite` during FETCH -> ignored, `pc` unaffected.
- Reset in DSTROBE of a write -> `memWrite` low next cycle, state IDLE, no `done`, `dataAdd`=0.
